// File: rtl/brq_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package brq_pkg;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} mdu_state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_div_step #(
   parameter int unsigned DataWidth = 32
) (
   input  logic [DataWidth:0]   part_rem,
   input  logic                 dvd_bit,
   input  logic [DataWidth-1:0] divisor,
   output logic [DataWidth:0]   next_rem,
   output logic                 quo_bit
);

   logic [DataWidth+1:0] shifted;
   logic [DataWidth+1:0] diff;

   always_comb begin
      shifted  = {part_rem, dvd_bit};
      diff     = shifted - {2'b00, divisor};
      quo_bit  = (shifted >= {2'b00, divisor});
      next_rem = (DataWidth+1)'(quo_bit ? diff : shifted);
   end

endmodule

// File: rtl/ieu_mdu_seq.sv
// RV32M sequencer: fixed-latency multiplier and 32-step restoring divider behind a stall/done handshake.
module ieu_mdu_seq
   import brq_pkg::*;
#(
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned RegAddrWidth = 5,
   parameter int unsigned MulLatency   = 2
) (
   input  logic                    brq_clk,
   input  logic                    brq_rst_n,
   input  logic                    mdu_start,
   input  logic                    mdu_kill,
   input  logic [2:0]              mdu_func3,
   input  logic [DataWidth-1:0]    mdu_op_a,
   input  logic [DataWidth-1:0]    mdu_op_b,
   input  logic [RegAddrWidth-1:0] mdu_addr_dst,
   output logic                    mdu_busy,
   output logic                    mdu_done,
   output logic [DataWidth-1:0]    mdu_result,
   output logic [RegAddrWidth-1:0] mdu_addr_dst_o,
   output logic                    mdu_regfile_en
);

   mdu_state_e state_q, state_d;

   logic [2:0]              func3_q;
   logic [DataWidth-1:0]    op_a_q, op_b_q, quo_q, res_q;
   logic [DataWidth:0]      rem_q;
   logic [RegAddrWidth-1:0] addr_q, addr_o_q;
   logic [4:0]              cnt_q;
   logic                    q_neg_q, r_neg_q;

   logic                    accept, special, sgn_div, a_sign, b_sign;
   logic [DataWidth-1:0]    mag_a, mag_b, special_res;
   logic                    mul_a_sgn, mul_b_sgn;
   logic signed [DataWidth:0]     mul_a_ext, mul_b_ext;
   logic signed [2*DataWidth+1:0] prod;
   logic [DataWidth-1:0]    mul_res, quo_fix, rem_fix, div_res;
   logic [DataWidth:0]      step_rem;
   logic                    step_q;

   // Accept-side decode works on the raw issue inputs.
   always_comb begin
      accept  = (state_q == IDLE || state_q == DONE) && mdu_start && !mdu_kill;
      sgn_div = (mdu_func3 == F3_DIV) || (mdu_func3 == F3_REM);
      a_sign  = sgn_div && mdu_op_a[DataWidth-1];
      b_sign  = sgn_div && mdu_op_b[DataWidth-1];
      mag_a   = a_sign ? -mdu_op_a : mdu_op_a;
      mag_b   = b_sign ? -mdu_op_b : mdu_op_b;
      special = 1'b0;
      special_res = '0;
      if (mdu_func3[2]) begin
         if (mdu_op_b == '0) begin
            special     = 1'b1;
            special_res = mdu_func3[1] ? mdu_op_a : DIV_ZERO_Q;
         end else if (sgn_div && mdu_op_a == INT_MIN && mdu_op_b == '1) begin
            special     = 1'b1;
            special_res = mdu_func3[1] ? '0 : INT_MIN;
         end
      end
      mdu_busy = (state_q == MUL) || (state_q == DIV) || (state_q == FIX) || (accept && !special);
   end

   always_comb begin
      mul_a_sgn = 1'b0;
      mul_b_sgn = 1'b0;
      case (func3_q)
         F3_MULH:          begin mul_a_sgn = 1'b1; mul_b_sgn = 1'b1; end
         F3_MULHSU:        mul_a_sgn = 1'b1;
         F3_MUL, F3_MULHU: begin end
         default:          begin end
      endcase
      mul_a_ext = {mul_a_sgn && op_a_q[DataWidth-1], op_a_q};
      mul_b_ext = {mul_b_sgn && op_b_q[DataWidth-1], op_b_q};
      prod      = mul_a_ext * mul_b_ext;
      mul_res   = (func3_q == F3_MUL) ? DataWidth'(prod) : DataWidth'(prod >>> DataWidth);
      quo_fix   = q_neg_q ? -quo_q : quo_q;
      rem_fix   = r_neg_q ? -rem_q[DataWidth-1:0] : rem_q[DataWidth-1:0];
      div_res   = (func3_q == F3_REM || func3_q == F3_REMU) ? rem_fix : quo_fix;
   end

   mdu_div_step #(.DataWidth(DataWidth)) u_div_step (
      .part_rem (rem_q),
      .dvd_bit  (op_a_q[cnt_q]),
      .divisor  (op_b_q),
      .next_rem (step_rem),
      .quo_bit  (step_q)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               if (!mdu_func3[2]) state_d = MUL;
               else if (special)  state_d = DONE;
               else               state_d = DIV;
            end
         end
         MUL:     if (cnt_q == '0) state_d = DONE;
         DIV:     if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (mdu_kill) state_d = IDLE;
   end

   // Division reuses op_a_q/op_b_q to hold magnitudes; multiplies keep the raw operands.
   always_ff @(posedge brq_clk or negedge brq_rst_n) begin
      if (!brq_rst_n) begin
         state_q  <= IDLE;
         func3_q  <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         res_q    <= '0;
         addr_q   <= '0;
         addr_o_q <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            func3_q <= mdu_func3;
            addr_q  <= mdu_addr_dst;
            op_a_q  <= mdu_func3[2] ? mag_a : mdu_op_a;
            op_b_q  <= mdu_func3[2] ? mag_b : mdu_op_b;
            q_neg_q <= a_sign ^ b_sign;
            r_neg_q <= a_sign;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= mdu_func3[2] ? 5'd31 : 5'(MulLatency - 1);
            if (special) begin
               res_q    <= special_res;
               addr_o_q <= mdu_addr_dst;
            end
         end else begin
            case (state_q)
               MUL: begin
                  cnt_q <= cnt_q - 5'd1;
                  if (state_d == DONE) begin
                     res_q    <= mul_res;
                     addr_o_q <= addr_q;
                  end
               end
               DIV: begin
                  cnt_q <= cnt_q - 5'd1;
                  rem_q <= step_rem;
                  quo_q <= {quo_q[DataWidth-2:0], step_q};
               end
               FIX: begin
                  if (state_d == DONE) begin
                     res_q    <= div_res;
                     addr_o_q <= addr_q;
                  end
               end
               default: begin end
            endcase
         end
      end
   end

   always_comb begin
      mdu_done       = (state_q == DONE);
      mdu_result     = res_q;
      mdu_addr_dst_o = addr_o_q;
      mdu_regfile_en = mdu_done && (addr_o_q != '0);
   end

endmodule
